// File: rtl/add_req_initiator.sv
// add_req_initiator
//   Initiator side of the single-cycle start/valid adder protocol. Operand
//   pairs are queued in a small FIFO. One request at a time goes to the adder,
//   and the response (or a timeout error) is returned to the consumer.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand push handshake (in_a, in_b)
//   req_start, req_a/b    one-cycle request pulse and registered operands
//   rsp_valid, rsp_y      adder response (expected one cycle after req_start)
//   out_valid/out_ready   result handshake (out_sum, out_err)
//   proto_err             sticky flag: rsp_valid arrived outside WAIT
//   busy                  FSM not idle or FIFO not empty
//   dbg_state             current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
//   The sender holds valid and its data stable until that transfer happens.
//   valid never depends combinationally on ready. in_ready comes from the
//   registered FIFO count only, and out_valid comes from the registered state.
module add_req_initiator #(
  parameter int W       = 20,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         req_start,
  output logic [W-1:0] req_a,
  output logic [W-1:0] req_b,
  input  logic         rsp_valid,
  input  logic [W-1:0] rsp_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_err,
  output logic         proto_err,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [W-1:0]     req_a_q, req_a_d, req_b_q, req_b_d;
  logic [W-1:0]     out_sum_q, out_sum_d;
  logic             out_err_q, out_err_d;
  logic             proto_err_q, proto_err_d;
  logic             push, pop;

  logic [W-1:0] mem_a [DEPTH];
  logic [W-1:0] mem_b [DEPTH];

  assign in_ready = (count_q != FULL_CNT);
  assign push     = in_valid && in_ready;

  // FIFO storage has no reset; the emptied count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= in_a;
      mem_b[wr_ptr_q] <= in_b;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    req_a_d     = req_a_q;
    req_b_d     = req_b_q;
    out_sum_d   = out_sum_q;
    out_err_d   = out_err_q;
    proto_err_d = proto_err_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          req_a_d = mem_a[rd_ptr_q];
          req_b_d = mem_b[rd_ptr_q];
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A response in the last allowed cycle still counts as success.
        if (rsp_valid) begin
          out_sum_d = rsp_y;
          out_err_d = 1'b0;
          state_d   = RESP;
        end else if (timer_q == TMR_LAST) begin
          out_sum_d = '0;
          out_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A response outside WAIT is flagged, and its data is dropped.
    if (rsp_valid && (state_q != WAIT)) proto_err_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      req_a_q     <= '0;
      req_b_q     <= '0;
      out_sum_q   <= '0;
      out_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      req_a_q     <= req_a_d;
      req_b_q     <= req_b_d;
      out_sum_q   <= out_sum_d;
      out_err_q   <= out_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign req_start = (state_q == ISSUE);
  assign req_a     = req_a_q;
  assign req_b     = req_b_q;
  assign out_valid = (state_q == RESP);
  assign out_sum   = out_sum_q;
  assign out_err   = out_err_q;
  assign proto_err = proto_err_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_add_req_initiator.sv
// tb_add_req_initiator
//   Directed bench for add_req_initiator (W=20, DEPTH=4, TIMEOUT=8).
//   A small adder model answers one cycle after req_start while adder_en = 1.
//   A separate stray pulse path injects unsolicited responses.
//   Outputs are sampled on the falling edge. Inputs change there too.
module tb_add_req_initiator;
  localparam int W = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, req_start, rsp_valid, out_valid, out_ready;
  logic         out_err, proto_err, busy;
  logic [W-1:0] in_a, in_b, req_a, req_b, rsp_y, out_sum;
  logic [1:0]   dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  // adder model plus stray-response injector
  logic         adder_en, model_v, stray_v;
  logic [W-1:0] model_y, stray_y;
  assign rsp_valid = model_v | stray_v;
  assign rsp_y     = stray_v ? stray_y : model_y;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_v <= 1'b0;
      model_y <= '0;
    end else begin
      model_v <= adder_en && req_start;
      model_y <= req_a + req_b;
    end
  end

  add_req_initiator #(.W(W), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .req_start(req_start), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
    .proto_err(proto_err), .busy(busy), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int max_cyc);
    int k = 0;
    while (!out_valid && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_sum);
    push(a, b);
    wait_out(tag, 20);
    check({tag, " sum"}, 32'(out_sum), 32'(exp_sum));
    check({tag, " err"}, 32'(out_err), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int seen;
    int k;
    logic [W-1:0] a, b, e;

    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    adder_en = 1'b1; stray_v = 1'b0; stray_y = '0;
    rst_n = 1'b0;
    #1;
    check("rst req_start", 32'(req_start), 0);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst in_ready", 32'(in_ready), 1);
    check("rst proto_err", 32'(proto_err), 0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // single op: push at T, req_start in T+2, out_valid in T+4, idle at T+5
    in_valid = 1'b1; in_a = 20'd100; in_b = 20'd23;
    @(negedge clk);
    in_valid = 1'b0;
    check("single T+1 req_start", 32'(req_start), 0);
    check("single T+1 busy", 32'(busy), 1);
    @(negedge clk);
    check("single T+2 req_start", 32'(req_start), 1);
    check("single req_a", 32'(req_a), 100);
    check("single req_b", 32'(req_b), 23);
    @(negedge clk);
    check("single T+3 req_start", 32'(req_start), 0);
    check("single T+3 out_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("single T+4 out_valid", 32'(out_valid), 1);
    check("single sum", 32'(out_sum), 123);
    check("single err", 32'(out_err), 0);
    @(negedge clk);
    check("single T+5 out_valid", 32'(out_valid), 0);
    check("single T+5 busy", 32'(busy), 0);

    // wrap around 2^W
    run_op("wrap", 20'hFFFFF, 20'd1, 20'd0);
    check("wrap proto_err", 32'(proto_err), 0);

    // backpressure: 7 back-to-back offers, out_ready low
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 7; i++) begin
      a = W'(i * 10 + 1);
      b = W'(i);
      in_valid = 1'b1; in_a = a; in_b = b;
      if (in_ready) begin
        accepted++;
        exp_q.push_back(a + b);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp accepted", 32'(accepted), 5);
    check("bp in_ready full", 32'(in_ready), 0);
    wait_out("bp first", 20);
    check("bp first sum", 32'(out_sum), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp hold valid", 32'(out_valid), 1);
      check("bp hold sum", 32'(out_sum), 1);
    end
    out_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      wait_out("bp drain", 20);
      e = exp_q.pop_front();
      check("bp drain sum", 32'(out_sum), 32'(e));
      @(negedge clk);
      if (r == 0) begin
        check("bp idle in_ready", 32'(in_ready), 0);
        @(negedge clk);
        check("bp after pop in_ready", 32'(in_ready), 1);
      end
    end
    @(negedge clk);
    check("bp drained busy", 32'(busy), 0);

    // timeout: no response, then the next queued op completes
    adder_en = 1'b0;
    push(20'd5, 20'd6);
    push(20'd9, 20'd1);
    k = 0;
    while (!req_start && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("to req_start", 32'(req_start), 1);
    step(8);
    check("to cycle8 out_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("to cycle9 out_valid", 32'(out_valid), 1);
    check("to err", 32'(out_err), 1);
    check("to sum", 32'(out_sum), 0);
    adder_en = 1'b1;
    @(negedge clk);
    wait_out("to next", 20);
    check("to next sum", 32'(out_sum), 10);
    check("to next err", 32'(out_err), 0);
    @(negedge clk);

    // stray response while idle
    step(2);
    check("stray pre busy", 32'(busy), 0);
    stray_y = 20'd55; stray_v = 1'b1;
    @(negedge clk);
    stray_v = 1'b0;
    check("stray proto_err", 32'(proto_err), 1);
    check("stray out_valid", 32'(out_valid), 0);
    step(3);
    check("stray sticky", 32'(proto_err), 1);
    check("stray no out", 32'(out_valid), 0);
    run_op("stray next", 20'd30, 20'd12, 20'd42);
    check("stray still set", 32'(proto_err), 1);

    // reset mid-WAIT with 3 ops queued
    adder_en = 1'b0;
    push(20'd1, 20'd1);
    push(20'd2, 20'd2);
    push(20'd3, 20'd3);
    push(20'd4, 20'd4);
    step(1);
    check("rst2 in WAIT", 32'(dbg_state), 2);
    rst_n = 1'b0;
    #1;
    check("rst2 req_start", 32'(req_start), 0);
    check("rst2 req_a", 32'(req_a), 0);
    check("rst2 req_b", 32'(req_b), 0);
    check("rst2 out_valid", 32'(out_valid), 0);
    check("rst2 out_sum", 32'(out_sum), 0);
    check("rst2 out_err", 32'(out_err), 0);
    check("rst2 proto_err", 32'(proto_err), 0);
    check("rst2 busy", 32'(busy), 0);
    check("rst2 in_ready", 32'(in_ready), 1);
    step(2);
    rst_n = 1'b1;
    adder_en = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_start) seen = 1;
    end
    check("rst2 no req_start", 32'(seen), 0);
    run_op("rst2 new", 20'd7, 20'd8, 20'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
